fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction fetch stage sitting directly upstream of the decode stage and driving the instruction memory.
//  Holds the fetch PC and issues one word-aligned fetch per cycle to the instruction memory.
//  Captures each returned instruction word and its PC into a DEPTH-entry FIFO.
//  Decode drains the FIFO with a valid/ready handshake; branch redirects flush it.
// PARAMETERS
//  DEPTH     4             FIFO entries; power of two, >= 2
//  PTR_W     2             log2(DEPTH)
//  RESET_PC  32'h00000000  fetch PC after reset; bits [1:0] must be 0
// PORTS
//  CLK             in   1      clock; all state updates on negedge CLK, matching the memories and regfile
//  RST             in   1      asynchronous reset, active-low
//  imem_addr       out  32     fetch address to the instruction memory; equals fetch_pc, combinational
//  imem_size       out  2      constant 2'b10 (word)
//  imem_data       in   32     instruction word returned combinationally by the instruction memory
//  deq_valid       out  1      head entry present (count != 0)
//  deq_ready       in   1      decode accepts the head entry this cycle
//  deq_inst        out  32     head instruction; 32'h0 when empty
//  deq_pc          out  32     head PC; 32'h0 when empty
//  redirect_valid  in   1      branch/jump taken; flush the queue and refetch
//  redirect_pc     in   32     redirect target; bits [1:0] forced to 0 internally
//  halt            in   1      stop issuing new fetches
//  count           out  PTR_W+1  current occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (RST=0, async): fetch_pc=RESET_PC, head=tail=0, count=0, state=RUN.
//   Outputs during reset: deq_valid=0, deq_inst=0, deq_pc=0, imem_addr=RESET_PC, count=0.
//  State machine: RUN / HALT, registered.
//   RUN->HALT when halt=1 at the edge. HALT->RUN when halt=0 at the edge.
//   Push eligibility uses the registered state, so halt stops pushes from the cycle after it is sampled.
//  pop = deq_valid & deq_ready & ~redirect_valid.
//  push = (state==RUN) & ~redirect_valid & (count<DEPTH | pop).
//   Pushing when full is legal only with a same-cycle pop; no overflow, no drop.
//  On push: entry[tail]={fetch_pc, imem_data}; tail=tail+1 mod DEPTH; fetch_pc=fetch_pc+4.
//   fetch_pc wraps modulo 2^32 (32'hFFFFFFFC+4 -> 0).
//  On pop: head=head+1 mod DEPTH.
//  count: +1 on push only, -1 on pop only, unchanged on both or neither.
//  Redirect (highest priority, any state):
//   head=tail=0, count=0, fetch_pc={redirect_pc[31:2],2'b00}.
//   No push and no pop that cycle; a head presented with deq_ready=1 is discarded.
//   State transitions still follow halt.
//   First push after a redirect occurs at the next edge with the new fetch_pc, latency 1 cycle.
//  Fetch-to-dequeue latency: a word pushed at edge N is visible on deq_* after edge N, combinationally from the head entry.
//  Empty with deq_ready=1: no effect, no underflow.
//  HALT: pops continue, fetch_pc frozen, imem_addr still driven.
//  Reset mid-operation discards all entries immediately; no partial state survives.
// TESTING
//  1. Reset with RESET_PC=0x100, deq_ready=0, 4 cycles -> queue holds PCs 0x100,0x104,0x108,0x10C; count=4; imem_addr=0x110 held.
//  2. Full queue, deq_ready=1 every cycle -> one pop and one push per cycle; count stays 4; deq_pc increments by 4 per cycle with no gap.
//  3. Redirect to 0x203 while count=3 and deq_ready=1 -> next cycle count=0, deq_valid=0; following cycle deq_pc=0x200 and instruction matches mem[0x200].
//  4. halt=1 with count=2, deq_ready=1 -> drains to 0 in 2 cycles, deq_valid=0 thereafter; halt=0 -> fetch resumes at the frozen PC.
//  5. RESET_PC=0xFFFFFFF8, 3 pushes -> deq_pc sequence FFFFFFF8, FFFFFFFC, 00000000.
//  6. Assert RST=0 mid-stream with count=3 -> deq_valid, count and deq_* go to 0 immediately, before the next edge; release -> refetch from RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage feeding decode.
// Holds the fetch PC and issues one word fetch per cycle. Each returned word
// is captured with its PC into a DEPTH-entry FIFO. Decode drains the FIFO
// with valid/ready. A redirect flushes the FIFO and reloads the fetch PC.
// All state updates happen on negedge CLK, in step with the memories.
//
// Ports:
//   CLK, RST          clock (negedge active), async active-low reset
//   imem_addr/size    fetch address (= fetch_pc) and constant word size
//   imem_data         combinational instruction word for imem_addr
//   deq_valid/ready   head-entry handshake toward decode
//   deq_inst/deq_pc   head entry; zero when empty
//   redirect_valid/pc flush and restart fetch at redirect_pc (word aligned)
//   halt              stop issuing new fetches (pops continue)
//   count             occupancy, 0..DEPTH
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             CLK,
  input  logic             RST,
  output logic [31:0]      imem_addr,
  output logic [1:0]       imem_size,
  input  logic [31:0]      imem_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [31:0]      deq_inst,
  output logic [31:0]      deq_pc,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             halt,
  output logic [PTR_W:0]   count
);

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  state_t             state, state_nxt;
  logic [31:0]        fetch_pc;
  logic [PTR_W-1:0]   head, tail;
  logic [PTR_W:0]     cnt;
  entry_t             fifo [DEPTH];
  logic               push, pop;

  // State register.
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) state <= RUN;
    else      state <= state_nxt;
  end

  // Next state plus handshake decode. Push uses the registered state, so a
  // sampled halt only blocks pushes from the following cycle on. Redirect
  // suppresses both push and pop so a presented head is simply discarded.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (halt)  state_nxt = HALT;
      HALT:    if (!halt) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    pop  = deq_valid && deq_ready && !redirect_valid;
    push = (state == RUN) && !redirect_valid && ((cnt < CNT_FULL) || pop);
  end

  // Pointers, occupancy, fetch PC.
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
    end else begin
      if (push) begin
        tail     <= tail + 1'b1;
        fetch_pc <= fetch_pc + 32'd4;   // wraps modulo 2^32
      end
      if (pop) head <= head + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  // Entry storage needs no reset: nothing is visible while count is zero.
  always_ff @(negedge CLK) begin
    if (push) fifo[tail] <= '{pc: fetch_pc, inst: imem_data};
  end

  assign imem_addr = fetch_pc;
  assign imem_size = 2'b10;
  assign deq_valid = (cnt != '0);
  assign deq_inst  = deq_valid ? fifo[head].inst : 32'h0;
  assign deq_pc    = deq_valid ? fifo[head].pc   : 32'h0;
  assign count     = cnt;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        CLK = 1'b0;
  logic        RST, RST2;
  logic [31:0] imem_addr, imem_data, imem_addr2, imem_data2;
  logic [1:0]  imem_size, imem_size2;
  logic        deq_valid, deq_ready, deq_valid2, deq_ready2;
  logic [31:0] deq_inst, deq_pc, deq_inst2, deq_pc2;
  logic        redirect_valid, halt;
  logic [31:0] redirect_pc;
  logic [2:0]  count, count2;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  // Instruction memory model: every word distinct and derived from its address.
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_data  = inst_of(imem_addr);
  assign imem_data2 = inst_of(imem_addr2);

  fetch_queue #(.DEPTH(4), .PTR_W(2), .RESET_PC(32'h0000_0100)) dut (
    .CLK(CLK), .RST(RST), .imem_addr(imem_addr), .imem_size(imem_size),
    .imem_data(imem_data), .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_inst(deq_inst), .deq_pc(deq_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt), .count(count));

  fetch_queue #(.DEPTH(4), .PTR_W(2), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .CLK(CLK), .RST(RST2), .imem_addr(imem_addr2), .imem_size(imem_size2),
    .imem_data(imem_data2), .deq_valid(deq_valid2), .deq_ready(deq_ready2),
    .deq_inst(deq_inst2), .deq_pc(deq_pc2), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .halt(1'b0), .count(count2));

  typedef struct {
    logic        h, r, rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [2:0]  ecnt;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic h, input logic r, input logic rv, input logic [31:0] rpc,
                     input logic ev, input logic [31:0] epc, input logic [2:0] ecnt,
                     input logic [31:0] eaddr);
    vec_t v;
    v.h = h; v.r = r; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.ecnt = ecnt; v.eaddr = eaddr;
    vecs.push_back(v);
  endtask

  // Drive inputs after a posedge, let the negedge update state, check at the next posedge.
  task automatic step(input vec_t v, input int idx);
    halt = v.h; deq_ready = v.r; redirect_valid = v.rv; redirect_pc = v.rpc;
    @(negedge CLK);
    @(posedge CLK);
    chk($sformatf("v%0d valid", idx), {31'b0, deq_valid}, {31'b0, v.ev});
    chk($sformatf("v%0d count", idx), {29'b0, count}, {29'b0, v.ecnt});
    chk($sformatf("v%0d pc", idx), deq_pc, v.ev ? v.epc : 32'h0);
    chk($sformatf("v%0d inst", idx), deq_inst, v.ev ? inst_of(v.epc) : 32'h0);
    chk($sformatf("v%0d addr", idx), imem_addr, v.eaddr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    logic [31:0] exp2 [3];

    //  h  r  rv rpc           ev epc           cnt eaddr
    // Fill from reset with decode stalled.
    add(0, 0, 0, 32'h0,        1, 32'h100, 3'd1, 32'h104);
    add(0, 0, 0, 32'h0,        1, 32'h100, 3'd2, 32'h108);
    add(0, 0, 0, 32'h0,        1, 32'h100, 3'd3, 32'h10C);
    add(0, 0, 0, 32'h0,        1, 32'h100, 3'd4, 32'h110);
    add(0, 0, 0, 32'h0,        1, 32'h100, 3'd4, 32'h110);   // full: fetch held
    // Full and draining: one pop + one push per cycle.
    add(0, 1, 0, 32'h0,        1, 32'h104, 3'd4, 32'h114);
    add(0, 1, 0, 32'h0,        1, 32'h108, 3'd4, 32'h118);
    add(0, 1, 0, 32'h0,        1, 32'h10C, 3'd4, 32'h11C);
    // halt sampled: this edge still pushes; next edge pops only.
    add(1, 1, 0, 32'h0,        1, 32'h110, 3'd4, 32'h120);
    add(1, 1, 0, 32'h0,        1, 32'h114, 3'd3, 32'h120);
    add(0, 0, 0, 32'h0,        1, 32'h114, 3'd3, 32'h120);   // leaves HALT, no push yet
    // Redirect to misaligned target with count=3 and deq_ready=1.
    add(0, 1, 1, 32'h203,      0, 32'h0,   3'd0, 32'h200);
    add(0, 0, 0, 32'h0,        1, 32'h200, 3'd1, 32'h204);
    add(1, 0, 0, 32'h0,        1, 32'h200, 3'd2, 32'h208);
    // Halted drain from count=2.
    add(1, 1, 0, 32'h0,        1, 32'h204, 3'd1, 32'h208);
    add(1, 1, 0, 32'h0,        0, 32'h0,   3'd0, 32'h208);
    add(1, 1, 0, 32'h0,        0, 32'h0,   3'd0, 32'h208);   // empty pop ignored
    add(0, 0, 0, 32'h0,        0, 32'h0,   3'd0, 32'h208);
    add(0, 0, 0, 32'h0,        1, 32'h208, 3'd1, 32'h20C);   // resumes at frozen PC
    // Redirect together with halt: state still follows halt.
    add(1, 0, 1, 32'h301,      0, 32'h0,   3'd0, 32'h300);
    add(0, 0, 0, 32'h0,        0, 32'h0,   3'd0, 32'h300);
    add(0, 0, 0, 32'h0,        1, 32'h300, 3'd1, 32'h304);
    add(0, 0, 0, 32'h0,        1, 32'h300, 3'd2, 32'h308);
    add(0, 0, 0, 32'h0,        1, 32'h300, 3'd3, 32'h30C);

    halt = 0; deq_ready = 0; redirect_valid = 0; redirect_pc = 0; deq_ready2 = 0;
    RST = 1; RST2 = 1;
    #1 RST = 0; RST2 = 0;
    #1;
    chk("rst valid", {31'b0, deq_valid}, 32'h0);
    chk("rst count", {29'b0, count}, 32'h0);
    chk("rst pc", deq_pc, 32'h0);
    chk("rst inst", deq_inst, 32'h0);
    chk("rst addr", imem_addr, 32'h100);
    chk("rst size", {30'b0, imem_size}, 32'h2);
    @(posedge CLK);
    RST = 1;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Reset mid-stream with count=3: outputs clear before any clock edge.
    RST = 0;
    #1;
    chk("mid rst valid", {31'b0, deq_valid}, 32'h0);
    chk("mid rst count", {29'b0, count}, 32'h0);
    chk("mid rst pc", deq_pc, 32'h0);
    chk("mid rst inst", deq_inst, 32'h0);
    chk("mid rst addr", imem_addr, 32'h100);
    @(posedge CLK);
    RST = 1;
    v = '{h: 0, r: 0, rv: 0, rpc: 0, ev: 1, epc: 32'h100, ecnt: 3'd1, eaddr: 32'h104};
    step(v, 100);

    // PC wrap past 2^32 on the second instance, decode always ready.
    exp2 = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    deq_ready2 = 1;
    RST2 = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      @(posedge CLK);
      chk($sformatf("wrap pc%0d", k), deq_pc2, exp2[k]);
      chk($sformatf("wrap inst%0d", k), deq_inst2, inst_of(exp2[k]));
      chk($sformatf("wrap cnt%0d", k), {29'b0, count2}, 32'h1);
    end
    chk("wrap addr", imem_addr2, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
